// File: rtl/voice_mixer.sv
// voice_mixer: four-channel stereo mixer. Snapshots four signed voice samples
// with volume and pan on each accepted sample tick, multiply-accumulates them
// through one shared multiplier and presents saturated 16-bit left/right words.
module voice_mixer (
  input  logic               clk,
  input  logic               rst_active_low,
  input  logic               sample_tick,
  input  logic signed [15:0] voice_0,
  input  logic signed [15:0] voice_1,
  input  logic signed [15:0] voice_2,
  input  logic signed [15:0] voice_3,
  input  logic        [3:0]  vol_0,
  input  logic        [3:0]  vol_1,
  input  logic        [3:0]  vol_2,
  input  logic        [3:0]  vol_3,
  input  logic        [1:0]  pan_0,
  input  logic        [1:0]  pan_1,
  input  logic        [1:0]  pan_2,
  input  logic        [1:0]  pan_3,
  input  logic               mute,
  output logic signed [15:0] pcm_left,
  output logic signed [15:0] pcm_right,
  output logic               pcm_valid,
  output logic               busy,
  output logic               overrun
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMac  = 2'd1,
    StOut  = 2'd2
  } state_e;

  state_e state_q;
  logic [1:0] idx_q;

  // Frame snapshot, frozen for the whole frame
  logic signed [15:0] voice_q [4];
  logic        [3:0]  vol_q   [4];
  logic        [1:0]  pan_q   [4];
  logic               mute_q;

  logic signed [17:0] acc_l_q;
  logic signed [17:0] acc_r_q;

  logic               accept;
  logic signed [15:0] voice_sel;
  logic        [3:0]  vol_sel;
  logic        [1:0]  pan_sel;
  logic signed [20:0] product;
  logic signed [17:0] contrib;
  logic               add_left;
  logic               add_right;

  assign accept = (state_q == StIdle) && sample_tick;

  // Clamp an accumulator to the 16-bit signed output range
  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767) begin
      return 16'sh7fff;
    end else if (v < -18'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
  endfunction

  // Select the current channel's operands for the single shared multiplier
  always_comb begin
    voice_sel = voice_q[idx_q];
    vol_sel   = vol_q[idx_q];
    pan_sel   = pan_q[idx_q];
  end

  // Volume is unsigned, so it is zero-extended before the signed multiply;
  // the arithmetic shift floors toward negative infinity.
  assign product   = voice_sel * $signed({1'b0, vol_sel});
  assign contrib   = 18'(product >>> 4);
  assign add_left  = (pan_sel == 2'b00) || (pan_sel == 2'b01);
  assign add_right = (pan_sel == 2'b00) || (pan_sel == 2'b10);

  // Control FSM with registered outputs; a tick outside idle is dropped
  always_ff @(posedge clk or negedge rst_active_low) begin
    if (!rst_active_low) begin
      state_q   <= StIdle;
      idx_q     <= 2'd0;
      pcm_left  <= '0;
      pcm_right <= '0;
      pcm_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      pcm_valid <= 1'b0;
      if (sample_tick && (state_q != StIdle)) begin
        overrun <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (sample_tick) begin
            state_q <= StMac;
            idx_q   <= 2'd0;
            busy    <= 1'b1;
          end
        end
        StMac: begin
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_q <= StOut;
          end
        end
        StOut: begin
          if (mute_q) begin
            pcm_left  <= '0;
            pcm_right <= '0;
          end else begin
            pcm_left  <= sat16(acc_l_q);
            pcm_right <= sat16(acc_r_q);
          end
          pcm_valid <= 1'b1;
          busy      <= 1'b0;
          state_q   <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Snapshot inputs on an accepted tick and accumulate one channel per MAC cycle
  always_ff @(posedge clk or negedge rst_active_low) begin
    if (!rst_active_low) begin
      for (int i = 0; i < 4; i++) begin
        voice_q[i] <= '0;
        vol_q[i]   <= '0;
        pan_q[i]   <= '0;
      end
      mute_q  <= 1'b0;
      acc_l_q <= '0;
      acc_r_q <= '0;
    end else if (accept) begin
      voice_q[0] <= voice_0;
      voice_q[1] <= voice_1;
      voice_q[2] <= voice_2;
      voice_q[3] <= voice_3;
      vol_q[0]   <= vol_0;
      vol_q[1]   <= vol_1;
      vol_q[2]   <= vol_2;
      vol_q[3]   <= vol_3;
      pan_q[0]   <= pan_0;
      pan_q[1]   <= pan_1;
      pan_q[2]   <= pan_2;
      pan_q[3]   <= pan_3;
      mute_q     <= mute;
      acc_l_q    <= '0;
      acc_r_q    <= '0;
    end else if (state_q == StMac) begin
      // Four contributions of at most 30720 in magnitude fit in 18 bits
      if (add_left) begin
        acc_l_q <= acc_l_q + contrib;
      end
      if (add_right) begin
        acc_r_q <= acc_r_q + contrib;
      end
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
// Self-checking bench for voice_mixer: expected frames are pushed to a
// scoreboard when a tick is driven and popped when pcm_valid pulses.
module tb_voice_mixer;

  logic               clk;
  logic               rst_active_low;
  logic               sample_tick;
  logic signed [15:0] voice [4];
  logic        [3:0]  vol   [4];
  logic        [1:0]  pan   [4];
  logic               mute;
  logic signed [15:0] pcm_left;
  logic signed [15:0] pcm_right;
  logic               pcm_valid;
  logic               busy;
  logic               overrun;

  typedef struct {
    int l;
    int r;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   valid_count = 0;

  voice_mixer dut (
    .clk            (clk),
    .rst_active_low (rst_active_low),
    .sample_tick    (sample_tick),
    .voice_0        (voice[0]),
    .voice_1        (voice[1]),
    .voice_2        (voice[2]),
    .voice_3        (voice[3]),
    .vol_0          (vol[0]),
    .vol_1          (vol[1]),
    .vol_2          (vol[2]),
    .vol_3          (vol[3]),
    .pan_0          (pan[0]),
    .pan_1          (pan[1]),
    .pan_2          (pan[2]),
    .pan_3          (pan[3]),
    .mute           (mute),
    .pcm_left       (pcm_left),
    .pcm_right      (pcm_right),
    .pcm_valid      (pcm_valid),
    .busy           (busy),
    .overrun        (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference mix: integer multiply, floor shift, sum, saturate, mute
  function automatic exp_t model();
    exp_t e;
    int   l = 0;
    int   r = 0;
    for (int i = 0; i < 4; i++) begin
      int c;
      c = (int'(voice[i]) * int'({28'd0, vol[i]})) >>> 4;
      if (pan[i] == 2'b00 || pan[i] == 2'b01) l += c;
      if (pan[i] == 2'b00 || pan[i] == 2'b10) r += c;
    end
    if (l > 32767) l = 32767;
    if (l < -32768) l = -32768;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    if (mute) begin
      l = 0;
      r = 0;
    end
    e.l = l;
    e.r = r;
    return e;
  endfunction

  // Scoreboard consumer
  always @(negedge clk) begin
    if (rst_active_low && pcm_valid) begin
      valid_count++;
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pcm_left", int'(pcm_left), e.l);
        check("pcm_right", int'(pcm_right), e.r);
      end
    end
  end

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) begin
      voice[i] = '0;
      vol[i]   = '0;
      pan[i]   = 2'b00;
    end
    mute = 1'b0;
  endtask

  // Drive one frame; optionally change voice_0 at edge 2 or re-tick at edge 3
  task automatic run_frame(input string tag, input bit chg_voice, input bit extra_tick);
    logic [15:0] vseen;
    vseen = '0;
    @(negedge clk);
    sample_tick = 1'b1;
    sb.push_back(model());
    @(posedge clk);
    @(negedge clk);
    sample_tick = 1'b0;
    check({tag, "_busy_on"}, int'(busy), 1);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      vseen[i] = pcm_valid;
      if (i == 1 && chg_voice) voice[0] = -16'sd16000;
      if (i == 2 && extra_tick) sample_tick = 1'b1;
      if (i == 3 && extra_tick) sample_tick = 1'b0;
    end
    check({tag, "_valid_timing"}, int'(vseen), 32'h20);
    check({tag, "_busy_off"}, int'(busy), 0);
  endtask

  initial begin
    int vc0;
    rst_active_low = 1'b0;
    sample_tick    = 1'b0;
    clear_inputs();

    // Ticks during reset must have no effect
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sample_tick = ~sample_tick;
    end
    @(negedge clk);
    sample_tick = 1'b0;
    check("rst_left", int'(pcm_left), 0);
    check("rst_right", int'(pcm_right), 0);
    check("rst_valid", int'(pcm_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    rst_active_low = 1'b1;
    repeat (2) @(negedge clk);

    run_frame("zero", 1'b0, 1'b0);

    clear_inputs();
    voice[0] = 16'sd16000; vol[0] = 4'd15;
    run_frame("centre", 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      voice[i] = 16'sd32767; vol[i] = 4'd15; pan[i] = 2'b00;
    end
    run_frame("sat_pos", 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) voice[i] = -16'sd32768;
    run_frame("sat_neg", 1'b0, 1'b0);

    clear_inputs();
    voice[1] = -16'sd1000; vol[1] = 4'd8; pan[1] = 2'b01;
    voice[2] = 16'sd1000;  vol[2] = 4'd1; pan[2] = 2'b10;
    run_frame("pan", 1'b0, 1'b0);

    clear_inputs();
    voice[0] = -16'sd1; vol[0] = 4'd1;
    run_frame("floor", 1'b0, 1'b0);

    clear_inputs();
    voice[0] = 16'sd1600;  vol[0] = 4'd15;
    voice[3] = 16'sd20000; vol[3] = 4'd15; pan[3] = 2'b11;
    run_frame("pan_mute", 1'b0, 1'b0);

    clear_inputs();
    voice[0] = 16'sd16000; vol[0] = 4'd15;
    run_frame("snapshot", 1'b1, 1'b0);

    voice[0] = 16'sd16000; mute = 1'b1;
    run_frame("mute", 1'b1, 1'b0);
    mute = 1'b0;
    check("no_overrun_yet", int'(overrun), 0);

    // Second tick at edge 3 must be dropped and flag overrun
    voice[0] = 16'sd8000;
    run_frame("overrun", 1'b0, 1'b1);
    check("overrun_set", int'(overrun), 1);
    voice[0] = 16'sd4000;
    run_frame("after_overrun", 1'b0, 1'b0);
    check("overrun_sticky", int'(overrun), 1);

    // Mid-frame reset at edge 2: frame aborted, no pulse
    vc0 = valid_count;
    @(negedge clk);
    sample_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sample_tick = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_active_low = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_left", int'(pcm_left), 0);
    check("mid_rst_right", int'(pcm_right), 0);
    check("mid_rst_valid", int'(pcm_valid), 0);
    check("mid_rst_overrun", int'(overrun), 0);
    repeat (3) @(negedge clk);
    rst_active_low = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_rst_no_pulse", valid_count - vc0, 0);
    check("mid_rst_left_hold", int'(pcm_left), 0);

    check("sb_drained", sb.size(), 0);
    check("valid_total", valid_count, 11);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
